// File: rtl/db_arbiter.sv
// Two-master round-robin arbiter in front of the single 32-bit data-bus slave.
// Optional busy watchdog is enabled with `define DB_ARB_TIMEOUT_EN.
module db_arbiter #(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          res,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_dataOut,
  input  logic          m0_re,
  input  logic          m0_we,
  input  logic          m0_io,
  output logic [DW-1:0] m0_dataIn,
  output logic          m0_ready,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_dataOut,
  input  logic          m1_re,
  input  logic          m1_we,
  input  logic          m1_io,
  output logic [DW-1:0] m1_dataIn,
  output logic          m1_ready,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_dataOut,
  output logic          s_re,
  output logic          s_we,
  output logic          s_io,
  input  logic [DW-1:0] s_dataIn,
  input  logic          s_ready,
  output logic [1:0]    grant,
  output logic          timeout_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [DW-1:0] TMO_DATA = DW'(32'hDEADBEEF);

  state_t     state_r, state_nxt_s;
  logic [1:0] grant_r, grant_nxt_s;
  logic       last_r, last_nxt_s;
  logic       req0_s, req1_s, own_req_s, done_s, abort_s, tmo_s;

  assign req0_s    = m0_re | m0_we;
  assign req1_s    = m1_re | m1_we;
  assign own_req_s = (grant_r[0] & req0_s) | (grant_r[1] & req1_s);
  assign done_s    = (state_r == BUSY) & s_ready;
  assign abort_s   = (state_r == BUSY) & ~s_ready & ~own_req_s;
  assign grant     = grant_r;

`ifdef DB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_r;

  // Busy-cycle counter: held at zero in IDLE so each grant starts counting from 0.
  always_ff @(posedge clk) begin
    if (res) begin
      timer_r <= {TW{1'b0}};
    end else if (state_r == IDLE) begin
      timer_r <= {TW{1'b0}};
    end else begin
      timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  // A slave answer in the final cycle wins over the watchdog.
  assign tmo_s = (state_r == BUSY) & ~s_ready & own_req_s & (timer_r == TMO_LAST);
`else
  assign tmo_s = 1'b0;
`endif

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r <= IDLE;
      grant_r <= 2'b00;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Arbitration in IDLE; release on completion, abort or watchdog in BUSY.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    last_nxt_s  = last_r;
    case (state_r)
      IDLE: begin
        if (req0_s && req1_s) begin
          state_nxt_s = BUSY;
          if (last_r) begin
            grant_nxt_s = 2'b01;
            last_nxt_s  = 1'b0;
          end else begin
            grant_nxt_s = 2'b10;
            last_nxt_s  = 1'b1;
          end
        end else if (req0_s) begin
          state_nxt_s = BUSY;
          grant_nxt_s = 2'b01;
          last_nxt_s  = 1'b0;
        end else if (req1_s) begin
          state_nxt_s = BUSY;
          grant_nxt_s = 2'b10;
          last_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
          grant_nxt_s = 2'b00;
        end
      end
      BUSY: begin
        if (done_s || abort_s || tmo_s) begin
          state_nxt_s = IDLE;
          grant_nxt_s = 2'b00;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = 2'b00;
      end
    endcase
  end

  // Slave mirrors the owner while BUSY; only the owner sees ready and read data.
  always_comb begin
    s_addr      = {AW{1'b0}};
    s_dataOut   = {DW{1'b0}};
    s_re        = 1'b0;
    s_we        = 1'b0;
    s_io        = 1'b0;
    m0_dataIn   = {DW{1'b0}};
    m0_ready    = 1'b0;
    m1_dataIn   = {DW{1'b0}};
    m1_ready    = 1'b0;
    timeout_err = 1'b0;
    if (state_r == BUSY) begin
      timeout_err = tmo_s;
      case (grant_r)
        2'b01: begin
          s_addr    = m0_addr;
          s_dataOut = m0_dataOut;
          s_re      = m0_re;
          s_we      = m0_we;
          s_io      = m0_io;
          m0_ready  = done_s | tmo_s;
          m0_dataIn = tmo_s ? TMO_DATA : s_dataIn;
        end
        2'b10: begin
          s_addr    = m1_addr;
          s_dataOut = m1_dataOut;
          s_re      = m1_re;
          s_we      = m1_we;
          s_io      = m1_io;
          m1_ready  = done_s | tmo_s;
          m1_dataIn = tmo_s ? TMO_DATA : s_dataIn;
        end
        default: begin
          s_re = 1'b0;
        end
      endcase
    end else begin
      timeout_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_db_arbiter.sv
// Directed self-checking bench for db_arbiter (TIMEOUT_CYCLES=8 instance).
module tb_db_arbiter;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] m0_addr, m0_dataOut, m0_dataIn;
  logic        m0_re, m0_we, m0_io, m0_ready;
  logic [31:0] m1_addr, m1_dataOut, m1_dataIn;
  logic        m1_re, m1_we, m1_io, m1_ready;
  logic [31:0] s_addr, s_dataOut, s_dataIn;
  logic        s_re, s_we, s_io, s_ready;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  db_arbiter #(.DW(32), .AW(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .res(res),
    .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_re(m0_re), .m0_we(m0_we), .m0_io(m0_io),
    .m0_dataIn(m0_dataIn), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_re(m1_re), .m1_we(m1_we), .m1_io(m1_io),
    .m1_dataIn(m1_dataIn), .m1_ready(m1_ready),
    .s_addr(s_addr), .s_dataOut(s_dataOut), .s_re(s_re), .s_we(s_we), .s_io(s_io),
    .s_dataIn(s_dataIn), .s_ready(s_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b1;
    tick();
    res = 1'b0;
  endtask

  initial begin
    res = 1'b0;
    m0_addr = 32'h0; m0_dataOut = 32'h0; m0_re = 1'b0; m0_we = 1'b0; m0_io = 1'b0;
    m1_addr = 32'h0; m1_dataOut = 32'h0; m1_re = 1'b0; m1_we = 1'b0; m1_io = 1'b0;
    s_dataIn = 32'h0; s_ready = 1'b0;
    do_reset();
    #1;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_s_re", 64'(s_re), 64'h0);
    chk("rst_s_addr", 64'(s_addr), 64'h0);
    chk("rst_m0_ready", 64'(m0_ready), 64'h0);
    chk("rst_tmo", 64'(timeout_err), 64'h0);

    // Single m0 read, slave answers in third busy cycle.
    m0_re = 1'b1; m0_addr = 32'h100;
    #1;
    chk("t1_idle_grant", 64'(grant), 64'h0);
    tick();
    #1;
    chk("t1_grant", 64'(grant), 64'h1);
    chk("t1_s_re", 64'(s_re), 64'h1);
    chk("t1_s_addr", 64'(s_addr), 64'h100);
    chk("t1_c1_ready", 64'(m0_ready), 64'h0);
    tick();
    #1;
    chk("t1_c2_ready", 64'(m0_ready), 64'h0);
    tick();
    s_ready = 1'b1; s_dataIn = 32'h12345678;
    #1;
    chk("t1_ready", 64'(m0_ready), 64'h1);
    chk("t1_data", 64'(m0_dataIn), 64'h12345678);
    chk("t1_m1_ready", 64'(m1_ready), 64'h0);
    chk("t1_m1_data", 64'(m1_dataIn), 64'h0);
    tick();
    s_ready = 1'b0; s_dataIn = 32'h0; m0_re = 1'b0;
    #1;
    chk("t1_release", 64'(grant), 64'h0);
    chk("t1_ready_once", 64'(m0_ready), 64'h0);

    // Both masters write continuously; grants must alternate starting with m0.
    do_reset();
    m0_we = 1'b1; m0_addr = 32'h10; m0_dataOut = 32'hA0A0A0A0;
    m1_we = 1'b1; m1_addr = 32'h20; m1_dataOut = 32'hB1B1B1B1;
    s_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_idle_grant", 64'(grant), 64'h0);
      chk("t2_idle_s_we", 64'(s_we), 64'h0);
      chk("t2_idle_ready", 64'({m1_ready, m0_ready}), 64'h0);
      tick();
      #1;
      chk("t2_s_addr", 64'(s_addr), (k % 2 == 0) ? 64'h10 : 64'h20);
      chk("t2_s_data", 64'(s_dataOut), (k % 2 == 0) ? 64'hA0A0A0A0 : 64'hB1B1B1B1);
      chk("t2_s_we", 64'(s_we), 64'h1);
      chk("t2_readies", 64'({m1_ready, m0_ready}), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end
    m0_we = 1'b0; m1_we = 1'b0; s_ready = 1'b0;

    // m1 write in progress; m0 arrives mid-transaction and must wait.
    m1_we = 1'b1; m1_addr = 32'h30; m1_io = 1'b1;
    tick();
    m0_re = 1'b1; m0_addr = 32'h40;
    #1;
    chk("t3_grant_m1", 64'(grant), 64'h2);
    chk("t3_s_addr", 64'(s_addr), 64'h30);
    chk("t3_s_io", 64'(s_io), 64'h1);
    chk("t3_s_re", 64'(s_re), 64'h0);
    chk("t3_m0_wait", 64'(m0_ready), 64'h0);
    tick();
    s_ready = 1'b1;
    #1;
    chk("t3_m1_ready", 64'({m1_ready, m0_ready}), 64'h2);
    tick();
    s_ready = 1'b0; m1_we = 1'b0; m1_io = 1'b0;
    #1;
    chk("t3_gap_grant", 64'(grant), 64'h0);
    chk("t3_gap_s_re", 64'(s_re), 64'h0);
    tick();
    m1_re = 1'b1; m1_addr = 32'h50;
    #1;
    chk("t3_grant_m0", 64'(grant), 64'h1);
    chk("t3_m0_addr", 64'(s_addr), 64'h40);
    chk("t3_m0_s_re", 64'(s_re), 64'h1);

    // Granted m0 abandons its read before the slave answers.
    tick();
    m0_re = 1'b0;
    #1;
    chk("t4_s_re_drop", 64'(s_re), 64'h0);
    chk("t4_no_ready", 64'({m1_ready, m0_ready}), 64'h0);
    tick();
    #1;
    chk("t4_idle", 64'(grant), 64'h0);
    tick();
    #1;
    chk("t4_m1_grant", 64'(grant), 64'h2);
    chk("t4_m1_addr", 64'(s_addr), 64'h50);
    chk("t4_m1_s_re", 64'(s_re), 64'h1);

    // Reset while m1 owns the bus drops the transaction silently.
    do_reset();
    m1_re = 1'b0;
    #1;
    chk("t5_grant", 64'(grant), 64'h0);
    chk("t5_s_ctl", 64'({s_re, s_we, s_io}), 64'h0);
    chk("t5_s_addr", 64'(s_addr), 64'h0);
    chk("t5_s_data", 64'(s_dataOut), 64'h0);
    s_ready = 1'b1; s_dataIn = 32'h99;
    #1;
    chk("t5_late_ready", 64'({m1_ready, m0_ready}), 64'h0);
    chk("t5_m1_data", 64'(m1_dataIn), 64'h0);
    tick();
    #1;
    chk("t5_still_idle", 64'(grant), 64'h0);
    chk("t5_still_no_ready", 64'({m1_ready, m0_ready}), 64'h0);
    s_ready = 1'b0; s_dataIn = 32'h0;

    // Slave never answers an m0 read.
    m0_re = 1'b1; m0_addr = 32'h60;
    tick();
`ifdef DB_ARB_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      #1;
      chk("t6_pre_tmo", 64'(timeout_err), 64'h0);
      chk("t6_pre_ready", 64'(m0_ready), 64'h0);
      tick();
    end
    #1;
    chk("t6_tmo", 64'(timeout_err), 64'h1);
    chk("t6_tmo_ready", 64'(m0_ready), 64'h1);
    chk("t6_tmo_data", 64'(m0_dataIn), 64'hDEADBEEF);
    chk("t6_tmo_m1", 64'(m1_ready), 64'h0);
    tick();
    m0_re = 1'b0;
    #1;
    chk("t6_tmo_idle", 64'(grant), 64'h0);
    chk("t6_tmo_clear", 64'(timeout_err), 64'h0);
`else
    for (int c = 0; c < 100; c++) begin
      #1;
      chk("t6_hold_grant", 64'(grant), 64'h1);
      chk("t6_hold_ready", 64'({timeout_err, m0_ready}), 64'h0);
      tick();
    end
    m0_re = 1'b0;
    #1;
    chk("t6_abort_s_re", 64'(s_re), 64'h0);
    tick();
    #1;
    chk("t6_abort_idle", 64'(grant), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
